pipelined_processor: RTL and testbench
======================================

Name: pipelined_processor

Overview:
- Self-contained 4-stage in-order pipelined processor: IF, ID, EX, WB.
- Executes a fixed program from an internal ROM-style instruction memory and reads operands from an internal constant data memory.
- Top-level simulation target with no data ports. Testbenches observe state hierarchically through the arrays `reg_file` and `PC`, which must carry exactly these names.

Parameters:
- DATA_W, 8, register/ALU/data-memory word width.
- IMEM_DEPTH, 16, instruction memory entries.
- DMEM_DEPTH, 16, data memory entries.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.

Behaviour:
- Internal state visible to benches:
  - `reg_file[0:15]`: DATA_W bits per entry.
  - `PC`: 8 bits.
- Instruction format, 16 bits:
  - op = [15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0], imm8 = [7:0].
- Opcodes (any other opcode executes as NOP):
  - 0 NOP.
  - 1 ADD: rd = rs1 + rs2.
  - 2 SUB: rd = rs1 - rs2.
  - 3 AND.
  - 4 OR.
  - 5 LDI: rd = imm8.
  - 6 LD: rd = dmem[imm8[3:0]].
- Arithmetic: modulo 2^DATA_W, no flags.
- R0 is hardwired to 0; writes to R0 are discarded.
- Memory contents:
  - dmem[n] = 10*n (constant).
  - Fetch with PC >= IMEM_DEPTH returns NOP.
- Default imem program:
  - 0: LDI R1,5
  - 1: LDI R2,3
  - 2: ADD R3,R1,R2
  - 3: SUB R4,R3,R1
  - 4: LD R5,[2]
  - 5..15: NOP
- Reset (synchronous): PC=0, all reg_file entries=0, all pipeline registers hold NOP with write-enable cleared. Reset asserted mid-program discards all in-flight instructions.
- Each non-reset edge:
  - PC <= PC+1, wrapping 255 -> 0.
  - IF/ID <= imem[PC].
  - ID/EX, EX/WB and the register write advance one stage.
- Latency: the instruction fetched at edge k (counted from the first edge with reset low, k = 1) writes reg_file at edge k+3.
- Hazards: resolved without stalls.
  - ID read bypass: a WB write in the same cycle to the same register supplies the new value.
  - EX forwarding: an operand matching the EX/WB destination (write-enable set, rd != 0) takes the EX/WB result.
  - Priority: EX/WB forward > ID-latched value.
- No branches; PC never stalls.

Decomposition:
- Package `pipelined_processor_pkg`: DATA_W, opcode constants, instruction field positions, NOP encoding.
- Sub-module `pp_alu`: combinational, op + two operands + imm -> result + write-enable.
- Memories, hazard logic and pipeline registers live in the top module.

Test Plan:
- Reset held 1 cycle, then released: first edge with reset low gives PC=1. All R0..R5=0 until edge 4.
- Run 10 cycles after release:
  - R1=5 at edge 4.
  - R2=3 at edge 5.
  - R3=8 at edge 6 (EX forwarding from LDI R2).
  - R4=3 at edge 7 (forwarding R3).
  - R5=20 at edge 8.
  - PC=10 at edge 10.
- R0 stays 0 throughout. A bench-overridden program containing `LDI R0,7` leaves R0=0.
- Reset reasserted at edge 6 for one cycle: PC=0, all registers 0, no later write from pre-reset instructions. Rerun reproduces the same sequence of values.
- Run 260 cycles: PC wraps to 0 after 255. Fetches at PC>=16 act as NOP; final R1..R5 = 5,3,8,3,20.
- Override imem with `LDI R1,200`, `LDI R2,100`, `ADD R3,R1,R2`: R3=44 (mod 256). `SUB R4,R2,R1` gives R4=156.

Source files
------------

// File: rtl/pipelined_processor_pkg.sv
// Shared definitions for the 4-stage pipelined processor.
// Contents: default word width, opcode encodings, instruction layout,
// NOP encoding, program image type with the default program, and the
// constant data-memory initialiser.
package pipelined_processor_pkg;

  localparam int PP_DATA_W = 8;   // default register/ALU/data word width
  localparam int INSTR_W   = 16;
  localparam int NREGS     = 16;
  localparam int PROG_MAX  = 16;  // entries held by a program image

  // Instruction field positions: op[15:12] rd[11:8] rs1[7:4] rs2[3:0],
  // imm8 overlays rs1:rs2.
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_LDI = 4'd5,
    OP_LD  = 4'd6
  } opcode_e;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 16'h0000;

  // Entry i of a program image lives at bits [16*i +: 16].
  typedef logic [PROG_MAX-1:0][INSTR_W-1:0] prog_t;

  // LDI R1,5 / LDI R2,3 / ADD R3,R1,R2 / SUB R4,R3,R1 / LD R5,[2] / NOPs
  localparam prog_t DEFAULT_PROG = {
    {11{INSTR_NOP}},
    16'h6502, 16'h2431, 16'h1312, 16'h5203, 16'h5105
  };

  // Data memory word n holds 10*n (truncated by the caller).
  function automatic int dmem_init(input int n);
    return 10 * n;
  endfunction

endpackage

// File: rtl/pp_alu.sv
// Combinational execute unit.
// Ports: op (4b opcode), a/b (register operands), mem_data (data memory
// word addressed by imm[3:0]), imm (8b immediate) -> result, we (the
// instruction produces a register write). Unknown opcodes act as NOP.
module pp_alu
  import pipelined_processor_pkg::*;
#(
  parameter int W = PP_DATA_W
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] mem_data,
  input  logic [7:0]   imm,
  output logic [W-1:0] result,
  output logic         we
);

  always_comb begin
    result = '0;
    we     = 1'b1;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_LDI:  result = W'(imm);
      OP_LD:   result = mem_data;
      default: we     = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipelined_processor.sv
// 4-stage in-order processor (IF, ID, EX, WB) running a fixed program
// from an internal ROM against a constant data memory. No data ports;
// state is observed through reg_file and PC.
// Ports: clk (rising-edge clock), reset (synchronous, active high).
// PROG selects the program image; the default is the built-in program.
module pipelined_processor
  import pipelined_processor_pkg::*;
#(
  parameter int    DATA_W     = PP_DATA_W,
  parameter int    IMEM_DEPTH = 16,
  parameter int    DMEM_DEPTH = 16,
  parameter prog_t PROG       = DEFAULT_PROG
) (
  input logic clk,
  input logic reset
);

  localparam int IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  typedef struct packed {
    logic [3:0]        op;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } id_ex_t;

  typedef struct packed {
    logic [3:0]        rd;
    logic [DATA_W-1:0] data;
    logic              we;
  } ex_wb_t;

  logic [7:0]        PC;
  logic [DATA_W-1:0] reg_file [0:NREGS-1];

  logic [INSTR_W-1:0] imem [0:IMEM_DEPTH-1];
  logic [DATA_W-1:0]  dmem [0:DMEM_DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < IMEM_DEPTH; gi++) begin : g_imem
      assign imem[gi] = PROG[gi];
    end
    for (gi = 0; gi < DMEM_DEPTH; gi++) begin : g_dmem
      assign dmem[gi] = DATA_W'(dmem_init(gi));
    end
  endgenerate

  instr_t if_id;
  id_ex_t id_ex;
  ex_wb_t ex_wb;

  // IF: addresses past the ROM fetch NOPs (PC keeps counting to 255).
  logic [INSTR_W-1:0] fetch;
  assign fetch = (int'(PC) < IMEM_DEPTH) ? imem[PC[IA_W-1:0]] : INSTR_NOP;

  // ID: register read with same-cycle writeback bypass, so an
  // instruction two ahead is visible even though its write lands on
  // the same edge that latches the operands.
  logic [DATA_W-1:0] rd_a, rd_b;
  always_comb begin
    rd_a = reg_file[if_id.rs1];
    rd_b = reg_file[if_id.rs2];
    if (ex_wb.we && ex_wb.rd == if_id.rs1) rd_a = ex_wb.data;
    if (ex_wb.we && ex_wb.rd == if_id.rs2) rd_b = ex_wb.data;
  end

  // EX: forward from the instruction one ahead. ex_wb.we is never set
  // for rd==0, which keeps R0 out of the forwarding paths.
  logic [DATA_W-1:0] op_a, op_b, mem_rd, alu_res;
  logic              alu_we;
  logic [3:0]        ld_idx;

  assign ld_idx = id_ex.rs2;  // imm8[3:0]
  assign op_a   = (ex_wb.we && ex_wb.rd == id_ex.rs1) ? ex_wb.data : id_ex.a;
  assign op_b   = (ex_wb.we && ex_wb.rd == id_ex.rs2) ? ex_wb.data : id_ex.b;
  assign mem_rd = (int'(ld_idx) < DMEM_DEPTH) ? dmem[ld_idx[DA_W-1:0]] : '0;

  pp_alu #(.W(DATA_W)) u_alu (
    .op       (id_ex.op),
    .a        (op_a),
    .b        (op_b),
    .mem_data (mem_rd),
    .imm      ({id_ex.rs1, id_ex.rs2}),
    .result   (alu_res),
    .we       (alu_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      PC    <= '0;
      if_id <= instr_t'(INSTR_NOP);
      id_ex <= '0;
      ex_wb <= '0;
      for (int r = 0; r < NREGS; r++) reg_file[r] <= '0;
    end else begin
      PC    <= PC + 8'd1;
      if_id <= instr_t'(fetch);

      id_ex.op  <= if_id.op;
      id_ex.rd  <= if_id.rd;
      id_ex.rs1 <= if_id.rs1;
      id_ex.rs2 <= if_id.rs2;
      id_ex.a   <= rd_a;
      id_ex.b   <= rd_b;

      ex_wb.rd   <= id_ex.rd;
      ex_wb.data <= alu_res;
      ex_wb.we   <= alu_we && (id_ex.rd != 4'd0);

      if (ex_wb.we) reg_file[ex_wb.rd] <= ex_wb.data;
    end
  end

endmodule

// File: tb/tb_pipelined_processor.sv
// Directed bench: built-in program timing, forwarding, R0 hardwiring,
// mid-run reset, PC wrap, and an overridden program exercising
// modulo arithmetic.
module tb_pipelined_processor;
  import pipelined_processor_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  // LDI R1,200 / LDI R2,100 / ADD R3,R1,R2 / SUB R4,R2,R1 / LDI R0,7
  localparam prog_t ALT_PROG = {
    {11{16'h0000}},
    16'h5007, 16'h2421, 16'h1312, 16'h5264, 16'h51C8
  };

  pipelined_processor dut (.clk(clk), .reset(reset));
  pipelined_processor #(.PROG(ALT_PROG)) dut2 (.clk(clk), .reset(reset2));

  always #5 clk = ~clk;

  // Built-in program: value written to R1..R5 and the edge it lands on.
  int exp_val  [1:5] = '{5, 3, 8, 3, 20};
  int exp_edge [1:5] = '{4, 5, 6, 7, 8};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (dut.PC !== 8'd0) $display("FAIL reset_pc: got %0d expected 0", dut.PC);
    else n_pass++;
    for (int r = 0; r <= 5; r++) begin
      n_checks++;
      if (dut.reg_file[r] !== 8'd0)
        $display("FAIL reset_R%0d: got %0d expected 0", r, dut.reg_file[r]);
      else n_pass++;
    end
  endtask

  // Release reset and step n edges, checking PC and R0..R5 after each.
  task automatic run_default(input int n, input string tag);
    int e;
    reset = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      n_checks++;
      if (dut.PC !== 8'(k))
        $display("FAIL %s_pc_edge%0d: got %0d expected %0d", tag, k, dut.PC, k);
      else n_pass++;
      n_checks++;
      if (dut.reg_file[0] !== 8'd0)
        $display("FAIL %s_R0_edge%0d: got %0d expected 0", tag, k, dut.reg_file[0]);
      else n_pass++;
      for (int r = 1; r <= 5; r++) begin
        e = (k >= exp_edge[r]) ? exp_val[r] : 0;
        n_checks++;
        if (dut.reg_file[r] !== 8'(e))
          $display("FAIL %s_R%0d_edge%0d: got %0d expected %0d",
                   tag, r, k, dut.reg_file[r], e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_program();
    run_default(10, "prog");
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    tick();
    run_default(5, "pre");
    reset = 1'b1;          // edge 6 happens with reset high
    tick();
    n_checks++;
    if (dut.PC !== 8'd0) $display("FAIL midrst_pc: got %0d expected 0", dut.PC);
    else n_pass++;
    for (int r = 0; r <= 5; r++) begin
      n_checks++;
      if (dut.reg_file[r] !== 8'd0)
        $display("FAIL midrst_R%0d: got %0d expected 0", r, dut.reg_file[r]);
      else n_pass++;
    end
    // Any in-flight write surviving reset would show up in the rerun.
    run_default(10, "rerun");
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 255; k++) tick();
    n_checks++;
    if (dut.PC !== 8'd255) $display("FAIL wrap_pc255: got %0d expected 255", dut.PC);
    else n_pass++;
    tick();
    n_checks++;
    if (dut.PC !== 8'd0) $display("FAIL wrap_pc0: got %0d expected 0", dut.PC);
    else n_pass++;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (dut.PC !== 8'd4) $display("FAIL wrap_pc4: got %0d expected 4", dut.PC);
    else n_pass++;
    for (int r = 1; r <= 5; r++) begin
      n_checks++;
      if (dut.reg_file[r] !== 8'(exp_val[r]))
        $display("FAIL wrap_R%0d: got %0d expected %0d", r, dut.reg_file[r], exp_val[r]);
      else n_pass++;
    end
    n_checks++;
    if (dut.reg_file[0] !== 8'd0) $display("FAIL wrap_R0: got %0d expected 0", dut.reg_file[0]);
    else n_pass++;
  endtask

  task automatic test_override();
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++;
      if (dut2.reg_file[0] !== 8'd0)
        $display("FAIL alt_R0_edge%0d: got %0d expected 0", k, dut2.reg_file[0]);
      else n_pass++;
      if (k == 5) begin
        n_checks++;
        if (dut2.reg_file[3] !== 8'd0)
          $display("FAIL alt_R3_early: got %0d expected 0", dut2.reg_file[3]);
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if (dut2.reg_file[3] !== 8'd44)
          $display("FAIL alt_R3_edge6: got %0d expected 44", dut2.reg_file[3]);
        else n_pass++;
      end
    end
    n_checks++;
    if (dut2.reg_file[1] !== 8'd200) $display("FAIL alt_R1: got %0d expected 200", dut2.reg_file[1]);
    else n_pass++;
    n_checks++;
    if (dut2.reg_file[2] !== 8'd100) $display("FAIL alt_R2: got %0d expected 100", dut2.reg_file[2]);
    else n_pass++;
    n_checks++;
    if (dut2.reg_file[3] !== 8'd44) $display("FAIL alt_R3: got %0d expected 44", dut2.reg_file[3]);
    else n_pass++;
    n_checks++;
    if (dut2.reg_file[4] !== 8'd156) $display("FAIL alt_R4: got %0d expected 156", dut2.reg_file[4]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_program();
    test_mid_reset();
    test_wrap();
    test_override();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
